jtframe_bram_sdram: RTL and testbench
=====================================

// Module: jtframe_bram_sdram
// PURPOSE
//  Responder end of the jtframe SDRAM slot interface: stands in for the SDRAM
//  controller and answers the sdram_req/sdram_ack/data_dst/data_rdy requests
//  issued by jtframe_rom.
//  Storage is an on-chip 16-bit BRAM. The BRAM is filled by the download path
//  (prog_* from jtframe_dwnld).
//  Used for GFX_ONLY/small-core builds and as a cycle-shaped SDRAM stand-in
//  for simulation. Latency is programmable, and periodic refresh stalls are
//  inserted.
// PARAMETERS
//  AW        22   address width of sdram_addr/prog_addr (word address)
//  MEM_AW    17   BRAM depth = 2**MEM_AW 16-bit words; addr[AW-1:MEM_AW]!=0 is out of range
//  LATENCY   4    cycles from ack to data_dst (>=1)
//  REF_PER   384  cycles between refresh windows (>=LATENCY+4)
//  REF_LEN   6    cycles per refresh window during which no request is accepted
// PORTS
//  clk          in   1     system clock (single domain)
//  rst          in   1     synchronous reset, active high
//  downloading  in   1     download in progress; reads are blocked
//  prog_addr    in   AW    download word address
//  prog_data    in   8     download byte, written to the byte lane(s) enabled by prog_mask
//  prog_mask    in   2     active-low byte enable; [0]=low byte, [1]=high byte
//  prog_we      in   1     write request, level-held until sdram_ack
//  sdram_req    in   1     read request, level-held until sdram_ack
//  sdram_addr   in   AW    read word address, sampled on the ack cycle
//  sdram_ack    out  1     1-cycle pulse: request (read or write) accepted
//  data_dst     out  1     1-cycle pulse: data_read now carries the first valid word
//  data_rdy     out  1     1-cycle pulse, cycle after data_dst: data complete
//  data_read    out  16    read data; held from data_dst until the next data_dst
// BEHAVIOUR
//  - Reset: sdram_ack=0, data_dst=0, data_rdy=0, data_read=0, FSM=IDLE,
//    refresh counter=0. BRAM contents are not cleared.
//  - FSM states:
//    IDLE -> REF    when refresh counter hits REF_PER-1. Takes priority over
//                   any pending request; counter restarts.
//    IDLE -> WR     when prog_we. Takes priority over sdram_req.
//    IDLE -> RD     when sdram_req && !downloading.
//    REF  -> IDLE   after REF_LEN cycles. No ack is issued in REF.
//    WR   -> IDLE   1 cycle. sdram_ack=1; BRAM written this cycle with
//                   {prog_data,prog_data} under ~prog_mask.
//    RD   -> WAIT   sdram_ack=1; addr latched.
//    WAIT -> DST    after LATENCY-1 cycles.
//    DST  -> RDY    data_dst=1; data_read updated to mem[addr], or 16'hFFFF if out of range.
//    RDY  -> IDLE   data_rdy=1.
//  - Refresh counter runs in every state. If it expires mid-read, REF is
//    entered after RDY, not inside the read.
//  - Ack latency: 1 cycle after req is seen in IDLE. A requester dropping req on
//    the cycle after ack must not re-trigger: IDLE evaluates req only from the
//    cycle following RDY/WR.
//  - Back-to-back reads: minimum 2+LATENCY+1 cycles per read. No pipelining, one outstanding read.
//  - Simultaneous prog_we and sdram_req: write wins; read waits in IDLE.
//  - downloading deasserting while req held: read accepted next IDLE cycle.
//  - Write out of range: acked, no BRAM change.
//  - rst mid-read: FSM to IDLE immediately; no dst/rdy for the aborted read.
// STRUCTURE
//  - Shared package jtframe_sdram_pkg:
//    state enum {IDLE,REF,WR,RD,WAIT,DST,RDY};
//    OOR_DATA=16'hFFFF.
//  - One sub-module jtframe_bram_bemask: single-port 16-bit BRAM with 2-bit
//    byte-enable write and registered read (1-cycle). The read is issued in the
//    last WAIT cycle, so DST sees valid q.
//  - Top holds the FSM, the wait counter, and the refresh counter.
// TESTING
//  - Write 0x5A to addr 0x10 with mask 2'b10, then 0xC3 with mask 2'b01 ->
//    read of 0x10 returns 16'hC35A. ack precedes dst by LATENCY cycles; rdy
//    follows dst by 1 cycle.
//  - Read addr 2**MEM_AW -> data_read=16'hFFFF, normal ack/dst/rdy timing.
//  - prog_we and sdram_req rise in the same cycle -> WR ack first; read ack no
//    earlier than 2 cycles later, and returns the newly written data.
//  - sdram_req held across refresh expiry (REF_PER=20) -> no ack during the
//    REF_LEN window; ack exactly 1 cycle after REF ends.
//  - sdram_req while downloading=1 -> no ack. Drop downloading -> ack 1 cycle
//    later.
//  - rst asserted in WAIT -> outputs 0 next cycle, no data_dst. A new req after
//    reset completes correctly.

Source files
------------

// File: rtl/jtframe_sdram_pkg.sv
// Shared definitions for the BRAM-backed SDRAM slot responder.
package jtframe_sdram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REF,
      WR,
      RD,
      WAIT,
      DST,
      RDY
   } state_t;

   // Word returned for reads that fall outside the BRAM window
   localparam logic [15:0] OOR_DATA = 16'hFFFF;

endpackage

// File: rtl/jtframe_bram_bemask.sv
// Single-port 16-bit BRAM with per-byte write enables and a registered read.
// The read port only updates q when re is high, so q holds its last word.
module jtframe_bram_bemask #(
   parameter int AW = 17
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   din,
   input  logic [1:0]    we,
   input  logic          re,
   output logic [15:0]   q
);

   logic [15:0] mem [0:(2**AW)-1];
   logic [15:0] q_reg;

   // Byte-lane writes and registered read on the shared address
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (we[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
      end
      if (re) q_reg <= mem[addr];
   end

   assign q = q_reg;

endmodule

// File: rtl/jtframe_bram_sdram.sv
// SDRAM slot responder backed by on-chip BRAM: accepts download writes and
// slot reads, returns data with a programmable latency and periodically
// stalls for a refresh window.
module jtframe_bram_sdram
   import jtframe_sdram_pkg::*;
#(
   parameter int AW      = 22,
   parameter int MEM_AW  = 17,
   parameter int LATENCY = 4,
   parameter int REF_PER = 384,
   parameter int REF_LEN = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          downloading,
   input  logic [AW-1:0] prog_addr,
   input  logic [7:0]    prog_data,
   input  logic [1:0]    prog_mask,
   input  logic          prog_we,
   input  logic          sdram_req,
   input  logic [AW-1:0] sdram_addr,
   output logic          sdram_ack,
   output logic          data_dst,
   output logic          data_rdy,
   output logic [15:0]   data_read
);

   // One down-counter serves both the wait phase and the refresh window
   localparam int CNT_MAX = (LATENCY > REF_LEN) ? LATENCY : REF_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int REF_W   = $clog2(REF_PER);

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [REF_W-1:0]    ref_cnt_reg;
   logic                ref_pend_reg, ref_pend_next;
   logic [MEM_AW-1:0]   addr_reg;
   logic                oor_reg;
   logic [15:0]         hold_reg;

   logic                ref_hit, ref_due;
   logic                sdram_in_range, prog_in_range;
   logic [MEM_AW-1:0]   mem_addr;
   logic [1:0]          mem_we;
   logic                mem_re;
   logic [15:0]         mem_q, rd_word;

   assign ref_hit        = (ref_cnt_reg == REF_W'(REF_PER - 1));
   // An expiry seen outside IDLE stays pending until IDLE can honour it
   assign ref_due        = ref_pend_reg || ref_hit;
   assign sdram_in_range = (sdram_addr[AW-1:MEM_AW] == '0);
   assign prog_in_range  = (prog_addr[AW-1:MEM_AW] == '0);

   // Next-state logic; refresh beats writes, writes beat reads
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (ref_due) begin
               state_next = REF;
               cnt_next   = CNT_W'(REF_LEN - 1);
            end else if (prog_we) begin
               state_next = WR;
            end else if (sdram_req && !downloading) begin
               state_next = RD;
            end
         end
         REF: begin
            if (cnt_reg == '0) state_next = IDLE;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         WR:   state_next = IDLE;
         RD: begin
            if (LATENCY == 1) begin
               state_next = DST;
            end else begin
               state_next = WAIT;
               cnt_next   = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
            end
         end
         WAIT: begin
            if (cnt_reg == '0) state_next = DST;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         DST:     state_next = RDY;
         RDY:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      ref_pend_next = ref_due && (state_reg != IDLE);
   end

   // The BRAM address follows the transaction: write address in WR, live
   // read address on the ack cycle, latched address afterwards
   assign mem_addr = (state_reg == WR) ? prog_addr[MEM_AW-1:0]  :
                     (state_reg == RD) ? sdram_addr[MEM_AW-1:0] : addr_reg;
   assign mem_we   = {2{(state_reg == WR) && prog_in_range}} & ~prog_mask;
   // Read is launched one cycle ahead of DST so q is valid there
   assign mem_re   = ((state_reg == RD) && (LATENCY == 1)) ||
                     ((state_reg == WAIT) && (cnt_reg == '0));

   jtframe_bram_bemask #(.AW(MEM_AW)) u_mem (
      .clk  (clk),
      .addr (mem_addr),
      .din  ({prog_data, prog_data}),
      .we   (mem_we),
      .re   (mem_re),
      .q    (mem_q)
   );

   assign rd_word   = oor_reg ? OOR_DATA : mem_q;
   assign sdram_ack = (state_reg == WR) || (state_reg == RD);
   assign data_dst  = (state_reg == DST);
   assign data_rdy  = (state_reg == RDY);
   assign data_read = (state_reg == DST) ? rd_word : hold_reg;

   // Control state, refresh timer and held read word
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         ref_cnt_reg  <= '0;
         ref_pend_reg <= 1'b0;
         hold_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         ref_pend_reg <= ref_pend_next;
         ref_cnt_reg  <= ref_hit ? '0 : ref_cnt_reg + 1'b1;
         if (state_reg == DST) hold_reg <= rd_word;
      end
   end

   // Read address and range flag captured on the ack cycle
   always_ff @(posedge clk) begin
      if (state_reg == RD) begin
         addr_reg <= sdram_addr[MEM_AW-1:0];
         oor_reg  <= !sdram_in_range;
      end
   end

endmodule

// File: tb/tb_jtframe_bram_sdram.sv
// Directed bench for the BRAM SDRAM responder: byte-masked writes, read
// timing, out-of-range access, write/read arbitration, refresh stall,
// download blocking and reset mid-read.
module tb_jtframe_bram_sdram;

   localparam int AW      = 22;
   localparam int MEM_AW  = 17;
   localparam int LATENCY = 4;
   localparam int REF_PER = 20;
   localparam int REF_LEN = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          downloading = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [7:0]    prog_data = '0;
   logic [1:0]    prog_mask = 2'b11;
   logic          prog_we = 1'b0;
   logic          sdram_req = 1'b0;
   logic [AW-1:0] sdram_addr = '0;
   logic          sdram_ack, data_dst, data_rdy;
   logic [15:0]   data_read;

   int n_checks = 0;
   int n_fail   = 0;

   jtframe_bram_sdram #(
      .AW(AW), .MEM_AW(MEM_AW), .LATENCY(LATENCY),
      .REF_PER(REF_PER), .REF_LEN(REF_LEN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_mask   (prog_mask),
      .prog_we     (prog_we),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .data_dst    (data_dst),
      .data_rdy    (data_rdy),
      .data_read   (data_read)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      prog_we = 1'b0;
      sdram_req = 1'b0;
      downloading = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Wait for ack, returning the number of cycles taken (limit+1 on timeout)
   task automatic wait_ack(output int n);
      for (n = 1; n <= 40; n++) begin
         tick();
         if (sdram_ack) break;
      end
   endtask

   task automatic finish_read(input string tag, input logic [15:0] exp);
      int m;
      for (m = 1; m <= 20; m++) begin
         tick();
         if (data_dst) break;
      end
      check_eq({tag, "_dst_lat"}, m, LATENCY);
      check_eq({tag, "_data"}, data_read, exp);
      tick();
      check_eq({tag, "_rdy"}, data_rdy, 1'b1);
      check_eq({tag, "_dst_low"}, data_dst, 1'b0);
      tick();
      check_eq({tag, "_hold"}, data_read, exp);
   endtask

   task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [7:0] d,
                           input logic [1:0] mask, output int n);
      prog_addr = a;
      prog_data = d;
      prog_mask = mask;
      prog_we   = 1'b1;
      wait_ack(n);
      prog_we   = 1'b0;
      $display("wr %s addr=%h data=%h mask=%b ack_wait=%0d", tag, a, d, mask, n);
      tick();
   endtask

   task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [15:0] exp,
                          output int n);
      sdram_addr = a;
      sdram_req  = 1'b1;
      wait_ack(n);
      sdram_req  = 1'b0;
      finish_read(tag, exp);
      $display("rd %s addr=%h data=%h ack_wait=%0d", tag, a, data_read, n);
   endtask

   initial begin
      int n;
      int cnt;

      // Reset state
      do_reset();
      check_eq("rst_ack", sdram_ack, 1'b0);
      check_eq("rst_dst", data_dst, 1'b0);
      check_eq("rst_rdy", data_rdy, 1'b0);
      check_eq("rst_data", data_read, 16'h0000);

      // Byte-masked writes merge into one word
      do_write("lo", 22'h000010, 8'h5A, 2'b10, n);
      check_eq("wr_lo_ack_wait", n, 1);
      do_write("hi", 22'h000010, 8'hC3, 2'b01, n);
      check_eq("wr_hi_ack_wait", n, 1);
      do_read("merge", 22'h000010, 16'hC35A, n);
      check_eq("merge_ack_wait", n, 1);

      // Out-of-range read and write
      do_reset();
      do_read("oor", 22'h020000, 16'hFFFF, n);
      check_eq("oor_ack_wait", n, 1);
      do_write("oor", 22'h020010, 8'h00, 2'b00, n);
      check_eq("oor_wr_ack_wait", n, 1);
      do_read("after_oor_wr", 22'h000010, 16'hC35A, n);

      // Write and read requested together: write wins
      do_reset();
      prog_addr  = 22'h000020;
      prog_data  = 8'h77;
      prog_mask  = 2'b00;
      prog_we    = 1'b1;
      sdram_addr = 22'h000020;
      sdram_req  = 1'b1;
      tick();
      check_eq("both_wr_ack", sdram_ack, 1'b1);
      prog_we = 1'b0;
      $display("wr both addr=000020 data=77 mask=00 ack_wait=1");
      wait_ack(n);
      sdram_req = 1'b0;
      check_eq("both_rd_ack_gap", n, 2);
      finish_read("both", 16'h7777);
      $display("rd both addr=000020 data=%h ack_wait=%0d", data_read, n);

      // Request held across refresh expiry at cycle REF_PER-1
      do_reset();
      for (int i = 0; i < REF_PER - 1; i++) tick();
      do_read("refresh", 22'h000010, 16'hC35A, n);
      check_eq("refresh_ack_wait", n, REF_LEN + 2);

      // Reads blocked while downloading
      do_reset();
      downloading = 1'b1;
      sdram_addr  = 22'h000010;
      sdram_req   = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (sdram_ack) cnt++;
      end
      check_eq("dl_no_ack", cnt, 0);
      downloading = 1'b0;
      do_read("dl_release", 22'h000010, 16'hC35A, n);
      check_eq("dl_release_ack_wait", n, 1);

      // Reset in the wait phase aborts the read
      do_reset();
      do_read("pre_abort", 22'h000010, 16'hC35A, n);
      sdram_addr = 22'h000020;
      sdram_req  = 1'b1;
      tick();
      check_eq("abort_ack", sdram_ack, 1'b1);
      sdram_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check_eq("abort_ack_low", sdram_ack, 1'b0);
      check_eq("abort_dst_low", data_dst, 1'b0);
      check_eq("abort_rdy_low", data_rdy, 1'b0);
      check_eq("abort_data", data_read, 16'h0000);
      rst = 1'b0;
      $display("rd abort addr=000020 reset in wait");
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (data_dst || data_rdy) cnt++;
      end
      check_eq("abort_no_dst", cnt, 0);
      do_read("post_abort", 22'h000020, 16'h7777, n);
      check_eq("post_abort_ack_wait", n, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
